// File: rtl/write_memory.sv
// Sequential pixel writer for a single-port image block RAM.
// Accepts a valid/ready pixel stream after a start pulse and writes each
// accepted pixel to consecutive RAM addresses beginning at start_address.
// After frame_len pixels the block parks in DONE until the next start.
// The RAM write port (wea/addra/dina) is fully registered, so a pixel
// accepted on one edge is written to the RAM on the following edge.
module write_memory #(
    parameter int          data_width    = 8,
    parameter int          addr_width    = 15,
    parameter int unsigned start_address = 0,
    parameter int unsigned frame_len     = 20000
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  start,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wea,
    output logic [addr_width-1:0] addra,
    output logic [data_width-1:0] dina,
    output logic [addr_width:0]   count,
    output logic                  done,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Base address truncated to the RAM address width; offsets wrap silently.
    localparam logic [addr_width-1:0] start_addr = addr_width'(start_address);
    // Count value at which the next accepted pixel completes the frame.
    localparam logic [addr_width:0]   last_count = (addr_width + 1)'(frame_len - 1);

    state_t                  state_reg;
    logic                    wea_reg;
    logic [addr_width-1:0]   addra_reg;
    logic [data_width-1:0]   dina_reg;
    logic [addr_width:0]     count_reg;
    logic                    done_reg;
    logic                    overrun_reg;

    logic                    accept;
    logic                    start_ok;

    // Ready depends only on state so the upstream stage never sees a
    // combinational path from its own valid back to ready.
    assign in_ready = (state_reg == WRITE);
    assign accept   = in_valid && in_ready;
    // A start pulse is only honoured outside an active frame.
    assign start_ok = start && (state_reg != WRITE);

    assign wea      = wea_reg;
    assign addra    = addra_reg;
    assign dina     = dina_reg;
    assign count    = count_reg;
    assign done     = done_reg;
    assign overrun  = overrun_reg;

    // Frame FSM plus the registered RAM write port and status flags.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_reg   <= IDLE;
            wea_reg     <= 1'b0;
            addra_reg   <= start_addr;
            dina_reg    <= '0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (start_ok) begin
            // New frame: clearing overrun here takes priority over a
            // simultaneous in_valid, which is not accepted on this edge.
            state_reg   <= WRITE;
            wea_reg     <= 1'b0;
            count_reg   <= '0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (in_valid && (state_reg != WRITE)) begin
                overrun_reg <= 1'b1;
            end
            if (accept) begin
                wea_reg   <= 1'b1;
                addra_reg <= start_addr + count_reg[addr_width-1:0];
                dina_reg  <= in_data;
                count_reg <= count_reg + 1'b1;
                if (count_reg == last_count) begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
            end else begin
                // Address and data hold; only the strobe drops.
                wea_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_write_memory.sv
// Self-checking bench for write_memory.
// Two instances share clock and reset: dut_a (base 0, 10-pixel frames) and
// dut_b (base 0x7FFE, 4-pixel frames) for the address wrap case.
// The reference model is a queue of pixels expected to be written, in order,
// to base+i; a negedge monitor logs every RAM write for comparison.
module tb_write_memory;

    localparam int DW    = 8;
    localparam int AW    = 15;
    localparam int LEN_A = 10;
    localparam int LEN_B = 4;
    localparam int BASE_B = 32'h7FFE;

    logic          clka = 1'b0;
    logic          rsta_n = 1'b0;

    logic          start_a = 1'b0, valid_a = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic          ready_a, wea_a, done_a, overrun_a;
    logic [AW-1:0] addra_a;
    logic [DW-1:0] dina_a;
    logic [AW:0]   count_a;

    logic          start_b = 1'b0, valid_b = 1'b0;
    logic [DW-1:0] data_b = '0;
    logic          ready_b, wea_b, done_b, overrun_b;
    logic [AW-1:0] addra_b;
    logic [DW-1:0] dina_b;
    logic [AW:0]   count_b;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t           cap_a[$];
    wr_t           cap_b[$];
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;

    write_memory #(.data_width(DW), .addr_width(AW), .start_address(0), .frame_len(LEN_A)) dut_a (
        .clka(clka), .rsta_n(rsta_n), .start(start_a), .in_data(data_a), .in_valid(valid_a),
        .in_ready(ready_a), .wea(wea_a), .addra(addra_a), .dina(dina_a),
        .count(count_a), .done(done_a), .overrun(overrun_a)
    );

    write_memory #(.data_width(DW), .addr_width(AW), .start_address(BASE_B), .frame_len(LEN_B)) dut_b (
        .clka(clka), .rsta_n(rsta_n), .start(start_b), .in_data(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .wea(wea_b), .addra(addra_b), .dina(dina_b),
        .count(count_b), .done(done_b), .overrun(overrun_b)
    );

    always #5 clka = ~clka;

    always @(posedge clka) cyc++;

    // Each write strobe spans one full cycle, so a negedge sample logs it once.
    always @(negedge clka) begin
        if (wea_a === 1'b1) begin
            cap_a.push_back('{addra_a, dina_a, cyc});
            $display("a: write addr=0x%04h data=0x%02h cyc=%0d", addra_a, dina_a, cyc);
        end
        if (wea_b === 1'b1) begin
            cap_b.push_back('{addra_b, dina_b, cyc});
            $display("b: write addr=0x%04h data=0x%02h cyc=%0d", addra_b, dina_b, cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Streams up to n pixels into dut_a; the model records every pixel
    // offered while the frame is open, since ready is high throughout WRITE.
    task automatic drive_a(input bit toggle, input bit rnd, input int n,
                           output int got, output int bad_ready);
        got = 0;
        bad_ready = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            logic          v;
            logic [DW-1:0] d;
            v = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            d = rnd ? DW'($urandom) : DW'(got);
            if (ready_a !== 1'b1) bad_ready++;
            valid_a = v;
            data_a  = d;
            tick();
            if (v) begin
                exp_a.push_back(d);
                got++;
            end
        end
        valid_a = 1'b0;
    endtask

    task automatic test_reset();
        rsta_n = 1'b0;
        repeat (2) tick();
        n_total++;
        if ({wea_a, ready_a, done_a, overrun_a} !== 4'b0000) begin
            $display("FAIL reset_flags_a: got wea/ready/done/overrun=%b required 0000",
                     {wea_a, ready_a, done_a, overrun_a});
        end else n_pass++;
        n_total++;
        if (addra_a !== 15'h0000 || dina_a !== 8'h00 || count_a !== 16'd0) begin
            $display("FAIL reset_regs_a: got addra=0x%h dina=0x%h count=%0d required 0,0,0",
                     addra_a, dina_a, count_a);
        end else n_pass++;
        n_total++;
        if (addra_b !== 15'h7FFE || wea_b !== 1'b0 || count_b !== 16'd0) begin
            $display("FAIL reset_regs_b: got addra=0x%h wea=%b count=%0d required 0x7ffe,0,0",
                     addra_b, wea_b, count_b);
        end else n_pass++;
        rsta_n = 1'b1;
        tick();
    endtask

    task automatic test_overrun();
        int got, bad;
        cap_a.delete(); exp_a.delete();
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        n_total++;
        if (overrun_a !== 1'b1 || ready_a !== 1'b0) begin
            $display("FAIL overrun_idle: got overrun=%b ready=%b required 1,0", overrun_a, ready_a);
        end else n_pass++;
        tick();
        n_total++;
        if (overrun_a !== 1'b1) begin
            $display("FAIL overrun_sticky: got %b required 1", overrun_a);
        end else n_pass++;
        pulse_start_a();
        n_total++;
        if (overrun_a !== 1'b0 || ready_a !== 1'b1) begin
            $display("FAIL overrun_cleared: got overrun=%b ready=%b required 0,1", overrun_a, ready_a);
        end else n_pass++;
        drive_a(1'b0, 1'b1, 3, got, bad);
        pulse_start_a();
        n_total++;
        if (count_a !== 16'd3 || ready_a !== 1'b1 || overrun_a !== 1'b0) begin
            $display("FAIL start_in_write: got count=%0d ready=%b overrun=%b required 3,1,0",
                     count_a, ready_a, overrun_a);
        end else n_pass++;
        drive_a(1'b0, 1'b1, LEN_A - 3, got, bad);
        tick();
        n_total++;
        if (cap_a.size() !== LEN_A || done_a !== 1'b1) begin
            $display("FAIL restart_ignored: got writes=%0d done=%b required %0d,1",
                     cap_a.size(), done_a, LEN_A);
        end else n_pass++;
        for (int i = 0; i < cap_a.size() && i < exp_a.size(); i++) begin
            n_total++;
            if (cap_a[i].addr !== AW'(i) || cap_a[i].data !== exp_a[i]) begin
                $display("FAIL restart_write[%0d]: got addr=0x%h data=0x%h required 0x%h,0x%h",
                         i, cap_a[i].addr, cap_a[i].data, AW'(i), exp_a[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_stream(input bit toggle);
        int got, bad;
        cap_a.delete(); exp_a.delete();
        pulse_start_a();
        n_total++;
        if (ready_a !== 1'b1 || done_a !== 1'b0 || count_a !== 16'd0) begin
            $display("FAIL stream_start: got ready=%b done=%b count=%0d required 1,0,0",
                     ready_a, done_a, count_a);
        end else n_pass++;
        drive_a(toggle, toggle, LEN_A, got, bad);
        n_total++;
        if (got !== LEN_A || bad !== 0) begin
            $display("FAIL stream_drive: got accepted=%0d ready_low_cycles=%0d required %0d,0",
                     got, bad, LEN_A);
        end else n_pass++;
        tick();
        n_total++;
        if (done_a !== 1'b1 || count_a !== 16'(LEN_A) || ready_a !== 1'b0 || wea_a !== 1'b0) begin
            $display("FAIL stream_end: got done=%b count=%0d ready=%b wea=%b required 1,%0d,0,0",
                     done_a, count_a, ready_a, wea_a, LEN_A);
        end else n_pass++;
        n_total++;
        if (cap_a.size() !== exp_a.size()) begin
            $display("FAIL stream_writes: got %0d writes required %0d", cap_a.size(), exp_a.size());
        end else n_pass++;
        for (int i = 0; i < cap_a.size() && i < exp_a.size(); i++) begin
            n_total++;
            if (cap_a[i].addr !== AW'(i) || cap_a[i].data !== exp_a[i] ||
                (!toggle && cap_a[i].cyc !== cap_a[0].cyc + i)) begin
                $display("FAIL stream_write[%0d]: got addr=0x%h data=0x%h cyc=%0d required 0x%h,0x%h,%0d",
                         i, cap_a[i].addr, cap_a[i].data, cap_a[i].cyc, AW'(i), exp_a[i],
                         cap_a[0].cyc + i);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int got, bad;
        cap_a.delete(); exp_a.delete();
        start_a = 1'b1;
        valid_a = 1'b1;
        data_a  = 8'hA5;
        tick();
        start_a = 1'b0;
        n_total++;
        if (done_a !== 1'b0 || overrun_a !== 1'b0 || ready_a !== 1'b1 || wea_a !== 1'b0) begin
            $display("FAIL b2b_start: got done=%b overrun=%b ready=%b wea=%b required 0,0,1,0",
                     done_a, overrun_a, ready_a, wea_a);
        end else n_pass++;
        tick();
        exp_a.push_back(8'hA5);
        n_total++;
        if (wea_a !== 1'b1 || addra_a !== 15'h0000 || dina_a !== 8'hA5 || count_a !== 16'd1) begin
            $display("FAIL b2b_first: got wea=%b addra=0x%h dina=0x%h count=%0d required 1,0,0xa5,1",
                     wea_a, addra_a, dina_a, count_a);
        end else n_pass++;
        drive_a(1'b0, 1'b1, LEN_A - 1, got, bad);
        tick();
        n_total++;
        if (cap_a.size() !== LEN_A || done_a !== 1'b1) begin
            $display("FAIL b2b_frame: got writes=%0d done=%b required %0d,1", cap_a.size(), done_a, LEN_A);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        cap_b.delete(); exp_b.delete();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < LEN_B; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            valid_b = 1'b1;
            data_b  = d;
            tick();
            exp_b.push_back(d);
        end
        valid_b = 1'b0;
        tick();
        n_total++;
        if (cap_b.size() !== LEN_B || done_b !== 1'b1 || count_b !== 16'(LEN_B)) begin
            $display("FAIL wrap_frame: got writes=%0d done=%b count=%0d required %0d,1,%0d",
                     cap_b.size(), done_b, count_b, LEN_B, LEN_B);
        end else n_pass++;
        for (int i = 0; i < cap_b.size() && i < LEN_B; i++) begin
            logic [AW-1:0] ea;
            ea = AW'((BASE_B + i) % (1 << AW));
            n_total++;
            if (cap_b[i].addr !== ea || cap_b[i].data !== exp_b[i]) begin
                $display("FAIL wrap_write[%0d]: got addr=0x%h data=0x%h required 0x%h,0x%h",
                         i, cap_b[i].addr, cap_b[i].data, ea, exp_b[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        int got, bad;
        pulse_start_a();
        drive_a(1'b0, 1'b1, 5, got, bad);
        #2;
        rsta_n = 1'b0;
        #1;
        n_total++;
        if ({wea_a, ready_a, done_a, overrun_a} !== 4'b0000 || addra_a !== 15'h0000 ||
            dina_a !== 8'h00 || count_a !== 16'd0) begin
            $display("FAIL midframe_reset: got wea/ready/done/overrun=%b addra=0x%h dina=0x%h count=%0d required 0000,0,0,0",
                     {wea_a, ready_a, done_a, overrun_a}, addra_a, dina_a, count_a);
        end else n_pass++;
        n_total++;
        if (done_b !== 1'b0 || addra_b !== 15'h7FFE) begin
            $display("FAIL midframe_reset_b: got done=%b addra=0x%h required 0,0x7ffe", done_b, addra_b);
        end else n_pass++;
        tick();
        cap_a.delete(); exp_a.delete();
        rsta_n = 1'b1;
        tick();
        n_total++;
        if (cap_a.size() !== 0 || ready_a !== 1'b0) begin
            $display("FAIL post_reset_idle: got writes=%0d ready=%b required 0,0", cap_a.size(), ready_a);
        end else n_pass++;
        pulse_start_a();
        drive_a(1'b0, 1'b1, LEN_A, got, bad);
        tick();
        n_total++;
        if (cap_a.size() !== LEN_A || done_a !== 1'b1) begin
            $display("FAIL rewrite_frame: got writes=%0d done=%b required %0d,1", cap_a.size(), done_a, LEN_A);
        end else n_pass++;
        for (int i = 0; i < cap_a.size() && i < exp_a.size(); i++) begin
            n_total++;
            if (cap_a[i].addr !== AW'(i) || cap_a[i].data !== exp_a[i]) begin
                $display("FAIL rewrite_write[%0d]: got addr=0x%h data=0x%h required 0x%h,0x%h",
                         i, cap_a[i].addr, cap_a[i].data, AW'(i), exp_a[i]);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_overrun();
        test_stream(1'b0);
        test_stream(1'b1);
        test_back_to_back();
        test_wrap();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/write_memory.md
# write_memory

Sequential pixel writer for the image block RAM. It accepts a valid/ready pixel stream and writes it into consecutive RAM addresses, from `start_address` for `frame_len` pixels, then signals completion. It is the write-side counterpart of the sequential ROM reader and sits between the text-extraction processing stage and the result memory (single-port Xilinx-style RAM: `clka`, `wea`, `addra`, `dina`).

## Interface
- `data_width`, 8, pixel width in bits
- `addr_width`, 15, RAM address width
- `start_address`, 0, first RAM address written in each frame
- `frame_len`, 20000, pixels per frame; legal range 1..2^addr_width

- `clka` input 1: sole clock, rising edge
- `rsta_n` input 1: asynchronous active-low reset
- `start` input 1: single-cycle pulse, begins a frame (honoured in IDLE and DONE only)
- `in_data` input data_width: pixel value
- `in_valid` input 1: `in_data` valid
- `in_ready` output 1: block accepts a pixel this cycle
- `wea` output 1: RAM write enable (registered)
- `addra` output addr_width: RAM address (registered)
- `dina` output data_width: RAM write data (registered)
- `count` output addr_width+1: pixels accepted in current/last frame
- `done` output 1: frame complete (level)
- `overrun` output 1: sticky, `in_valid` seen while not accepting

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: `in_ready`=0; `start`=1 -> WRITE, `count`<=0, `overrun`<=0.
- WRITE: `in_ready`=1 (combinational from state only). Accept = `in_valid` && `in_ready`.
  - On accept: `wea`<=1, `addra`<=(start_address+`count`) mod 2^addr_width, `dina`<=`in_data`, `count`<=`count`+1.
  - No accept: `wea`<=0; `addra`, `dina` hold.
  - Accept with `count`==frame_len-1 -> DONE.
  - `start` in WRITE ignored (no restart mid-frame).
- DONE: `in_ready`=0, `done`=1; `count` holds frame_len; `start`=1 -> WRITE as from IDLE, `done` cleared on that edge.
- `overrun`: set on any edge where `in_valid`=1 and state≠WRITE; cleared only by reset or an honoured `start`; if both on same edge, `start` wins (cleared).
- Address arithmetic wraps modulo 2^addr_width; no error on wrap.
- Reset (asynchronous, any time incl. mid-frame): state IDLE, `wea`=0, `addra`=start_address, `dina`=0, `count`=0, `done`=0, `overrun`=0, `in_ready`=0. Partial frame abandoned; no further writes.

## Timing
- `start` at edge N -> `in_ready`=1 during cycle N+1.
- Pixel accepted at edge K -> `wea`/`addra`/`dina` valid during cycle K..K+1 (one-cycle register latency); RAM write at edge K+1.
- Back-to-back: one pixel per cycle, no bubbles; `wea` high continuously while `in_valid` held.
- Last accept at edge L: `in_ready`=0 and `done`=1 from cycle after L; final `wea` pulse still asserted that cycle (last write completes at edge L+1).
- `done`->`start`->`in_ready` restart takes one cycle; no idle gap required.
- `frame_len`=1: single accept moves WRITE->DONE.

## Test plan
- Reset, `start`, stream 0x00..0x09 with frame_len=10, `in_valid` constant -> `wea` high 10 consecutive cycles, `addra` 0..9, `dina` 0x00..0x09, `done`=1, `count`=10.
- Same stream with `in_valid` toggled 1/0 -> exactly 10 writes, addresses contiguous, `wea` low on idle cycles, no duplicates.
- start_address=0x7FFE, frame_len=4 -> `addra` 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- `in_valid`=1 in IDLE then `start` -> `overrun`=1 before `start`, 0 after; pulse `start` in WRITE -> ignored, `count` unchanged.
- `rsta_n` low after 5 of 10 pixels -> all outputs at reset values immediately, `wea`=0; new `start` rewrites from start_address.
- `done`, then `start` on the same cycle as `in_valid` -> first pixel of new frame accepted next cycle to start_address, `done` cleared.
